// File: rtl/bit_sched_pkg.sv
// ----------------------------------------------------------------------------
// bit_sched_pkg
//
// Shared types for the bit-pixel buffer scheduler.
//   bank_state_t : ownership state of one bank of the bit-pixel RAMs
//   wr_state_t   : writer-side handshake state
//   rd_state_t   : reader-side handshake state
//   NUM_BANKS    : number of ping-pong banks (bank = MSB of the RAM address)
// ----------------------------------------------------------------------------
package bit_sched_pkg;

   localparam int NUM_BANKS = 2;

   typedef enum logic [1:0] {
      BANK_FREE,
      BANK_WRITING,
      BANK_FULL,
      BANK_READING
   } bank_state_t;

   typedef enum logic {
      W_IDLE,
      W_ACTIVE
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_ACTIVE
   } rd_state_t;

endpackage

// File: rtl/bit_buffer_scheduler.sv
// ----------------------------------------------------------------------------
// bit_buffer_scheduler
//
// Ping-pong controller for the two-bank bit-pixel RAMs shared by the bit-pixel
// writer and the bit-pixel reader. Banks are handed to the writer in order,
// finished banks are handed to the reader strictly 0,1,0,1... and the reader
// is launched by bumping image_number. The writer can never be granted a bank
// the reader owns.
//
// Optional feature (macro BIT_SCHED_DROP_EN): when the writer is stalled and
// the other bank holds an unread frame while the reader is busy, that frame is
// overwritten (recycled) and drop_count is incremented (saturating). Without
// the macro the writer simply stalls and drop_count is tied to 0.
//
// Ports:
//   pclk          in   pixel clock, sole clock
//   pclk_reset_n  in   synchronous active-low reset
//   wr_req        in   level: writer wants a bank for the next frame
//   wr_grant      out  1-cycle pulse: wr_bank is now owned by the writer
//   wr_bank       out  bank granted to the writer, held until next grant
//   wr_done       in   pulse: writer finished the frame in wr_bank
//   image_number  out  incremented once per reader launch (wraps)
//   rd_bank       out  bank the reader is consuming
//   rd_busy       out  high while the reader owns a bank
//   rd_done       in   pulse: reader finished rd_bank
//   banks_full    out  bit i high when bank i is written and unread
//   proto_err     out  sticky protocol-violation flag, cleared only by reset
//   drop_count    out  frames overwritten unread (saturating)
// ----------------------------------------------------------------------------
module bit_buffer_scheduler
   import bit_sched_pkg::*;
#(
   parameter int IMG_NUM_W  = 4,
   parameter int DROP_CNT_W = 8
) (
   input  logic                  pclk,
   input  logic                  pclk_reset_n,
   input  logic                  wr_req,
   output logic                  wr_grant,
   output logic                  wr_bank,
   input  logic                  wr_done,
   output logic [IMG_NUM_W-1:0]  image_number,
   output logic                  rd_bank,
   output logic                  rd_busy,
   input  logic                  rd_done,
   output logic [NUM_BANKS-1:0]  banks_full,
   output logic                  proto_err,
   output logic [DROP_CNT_W-1:0] drop_count
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   bank_state_t          bank_q [NUM_BANKS];
   bank_state_t          bank_d [NUM_BANKS];
   wr_state_t            wr_state_q, wr_state_d;
   rd_state_t            rd_state_q, rd_state_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_bank_q, wr_bank_d;
   logic                 wr_grant_q, wr_grant_d;
   logic                 rd_bank_q, rd_bank_d;
   logic                 rd_busy_q, rd_busy_d;
   logic                 proto_err_q, proto_err_d;
   logic [IMG_NUM_W-1:0] image_number_q, image_number_d;

   // -------------------------------------------------------------------------
   // Decisions, all taken from registered state
   // -------------------------------------------------------------------------
   logic grant_normal;
   logic grant_drop;
   logic grant_bank;
   logic rd_launch;
   logic wr_done_ok;
   logic rd_done_ok;
   logic bad_wr_done;
   logic bad_rd_done;

   assign grant_normal = (wr_state_q == W_IDLE) && wr_req && (bank_q[wr_ptr_q] == BANK_FREE);
   assign rd_launch    = (rd_state_q == R_IDLE) && (bank_q[rd_ptr_q] == BANK_FULL);

   // A wr_done landing in the grant cycle is illegal and must not retire the bank.
   assign wr_done_ok   = (wr_state_q == W_ACTIVE) && wr_done && !wr_grant_q;
   assign rd_done_ok   = (rd_state_q == R_ACTIVE) && rd_done;

   assign bad_wr_done  = wr_done && ((wr_state_q == W_IDLE) || wr_grant_q);
   assign bad_rd_done  = rd_done && (rd_state_q == R_IDLE);

   // A recycling grant takes the other bank; a normal grant takes wr_ptr.
   assign grant_bank   = grant_drop ? ~wr_ptr_q : wr_ptr_q;

`ifdef BIT_SCHED_DROP_EN
   logic                  wr_alt;
   logic [DROP_CNT_W-1:0] drop_count_q;

   assign wr_alt = ~wr_ptr_q;

   // Recycle the unread frame only while the reader is busy elsewhere; a reader
   // launch on the same bank in the same cycle takes precedence.
   assign grant_drop = (wr_state_q == W_IDLE) && wr_req
                    && (bank_q[wr_ptr_q] != BANK_FREE)
                    && (bank_q[wr_alt] == BANK_FULL)
                    && (rd_state_q == R_ACTIVE)
                    && !(rd_launch && (rd_ptr_q == wr_alt));

   always_ff @(posedge pclk) begin
      if (!pclk_reset_n) begin
         drop_count_q <= '0;
      end else if (grant_drop && (drop_count_q != '1)) begin
         drop_count_q <= drop_count_q + 1'b1;
      end
   end

   assign drop_count = drop_count_q;
`else
   assign grant_drop = 1'b0;
   assign drop_count = '0;
`endif

   // -------------------------------------------------------------------------
   // Next-state logic for both FSMs and the bank array
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      bank_d         = bank_q;
      wr_state_d     = wr_state_q;
      wr_ptr_d       = wr_ptr_q;
      wr_bank_d      = wr_bank_q;
      wr_grant_d     = 1'b0;
      rd_state_d     = rd_state_q;
      rd_ptr_d       = rd_ptr_q;
      rd_bank_d      = rd_bank_q;
      rd_busy_d      = rd_busy_q;
      image_number_d = image_number_q;
      proto_err_d    = proto_err_q | bad_wr_done | bad_rd_done;

      // Writer and reader always act on different banks (grant takes a FREE or
      // recycled FULL bank, launch takes the FULL bank at rd_ptr, retirements
      // act on the bank each side owns), so both updates can apply together.
      case (wr_state_q)
         W_IDLE: begin
            if (grant_normal || grant_drop) begin
               wr_grant_d         = 1'b1;
               wr_bank_d          = grant_bank;
               bank_d[grant_bank] = BANK_WRITING;
               wr_state_d         = W_ACTIVE;
            end
         end
         W_ACTIVE: begin
            if (wr_done_ok) begin
               bank_d[wr_bank_q] = BANK_FULL;
               wr_ptr_d          = ~wr_bank_q;
               wr_state_d        = W_IDLE;
            end
         end
         default: ;
      endcase

      case (rd_state_q)
         R_IDLE: begin
            if (rd_launch) begin
               image_number_d   = image_number_q + 1'b1;
               rd_bank_d        = rd_ptr_q;
               rd_busy_d        = 1'b1;
               bank_d[rd_ptr_q] = BANK_READING;
               rd_state_d       = R_ACTIVE;
            end
         end
         R_ACTIVE: begin
            if (rd_done_ok) begin
               bank_d[rd_bank_q] = BANK_FREE;
               rd_ptr_d          = ~rd_ptr_q;
               rd_busy_d         = 1'b0;
               rd_state_d        = R_IDLE;
            end
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (!pclk_reset_n) begin
         // NOTE: bank_q is a small register array, not RAM, and reset must
         // abandon all ownership, so every entry is reset explicitly.
         for (int i = 0; i < NUM_BANKS; i++) begin
            bank_q[i] <= BANK_FREE;
         end
         wr_state_q     <= W_IDLE;
         rd_state_q     <= R_IDLE;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         wr_bank_q      <= 1'b0;
         wr_grant_q     <= 1'b0;
         rd_bank_q      <= 1'b0;
         rd_busy_q      <= 1'b0;
         proto_err_q    <= 1'b0;
         image_number_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples the pre-edge values regardless of statement order.
         bank_q         <= bank_d;
         wr_state_q     <= wr_state_d;
         rd_state_q     <= rd_state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_bank_q      <= wr_bank_d;
         wr_grant_q     <= wr_grant_d;
         rd_bank_q      <= rd_bank_d;
         rd_busy_q      <= rd_busy_d;
         proto_err_q    <= proto_err_d;
         image_number_q <= image_number_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      banks_full = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         banks_full[i] = (bank_q[i] == BANK_FULL);
      end
   end

   assign wr_grant     = wr_grant_q;
   assign wr_bank      = wr_bank_q;
   assign image_number = image_number_q;
   assign rd_bank      = rd_bank_q;
   assign rd_busy      = rd_busy_q;
   assign proto_err    = proto_err_q;

endmodule

// File: doc/bit_buffer_scheduler.md
Name: bit_buffer_scheduler

Overview:
- Ping-pong controller for the two-bank bit-pixel RAMs (bank = MSB of the 16-bit RAM address) shared by the bit-pixel writer and the bit-pixel reader.
- Grants banks to the writer in order and launches the reader by bumping image_number.
- Guarantees the writer never touches a bank being read.
- Bank order to the reader is strictly 0,1,0,1…, matching the reader's internal buffer toggle.

Parameters:
IMG_NUM_W, 4, width of image_number; wraps modulo 2^IMG_NUM_W.
DROP_CNT_W, 8, width of drop_count; only used with BIT_SCHED_DROP_EN.

Ports:
pclk  in  1  pixel clock; sole clock.
pclk_reset_n  in  1  synchronous, active-low reset.
wr_req  in  1  level; writer wants a bank for the next frame.
wr_grant  out  1  one-cycle pulse; wr_bank is valid and owned by the writer.
wr_bank  out  1  bank granted to the writer; held until the next grant.
wr_done  in  1  pulse; writer finished the frame in wr_bank.
image_number  out  IMG_NUM_W  incremented once per reader launch.
rd_bank  out  1  bank the reader is consuming.
rd_busy  out  1  high while the reader owns a bank.
rd_done  in  1  pulse; reader finished all three thirds of rd_bank.
banks_full  out  2  bit i high when bank i is FULL (written, unread).
proto_err  out  1  sticky protocol-violation flag; cleared only by reset.
drop_count  out  DROP_CNT_W  frames overwritten unread; saturates; tied 0 without the macro.

Behaviour:
- Reset, when pclk_reset_n=0 at a pclk edge:
  - all banks FREE; wr_ptr=0, rd_ptr=0.
  - writer FSM W_IDLE, reader FSM R_IDLE.
  - all outputs 0: wr_grant, wr_bank, image_number, rd_bank, rd_busy, banks_full, proto_err, drop_count.
  - Reset mid-frame abandons all ownership with no flush. The reader must be reset in the same cycle.
- Bank state per bank: FREE, WRITING, FULL, READING. Transitions happen only via the rules below. All decisions use registered state, so an update is visible one cycle later.
- Writer FSM:
  - W_IDLE & wr_req & bank[wr_ptr]==FREE -> next cycle: wr_grant=1 for 1 cycle, wr_bank=wr_ptr, bank WRITING, W_ACTIVE. Grant latency 1 cycle from wr_req sampled.
  - W_ACTIVE & wr_done -> bank[wr_bank]=FULL, wr_ptr=~wr_bank, W_IDLE.
  - wr_req is ignored in W_ACTIVE.
  - A new grant is possible no earlier than the cycle after W_IDLE is re-entered.
- Reader FSM:
  - R_IDLE & bank[rd_ptr]==FULL -> next cycle: image_number+1 (wraps 2^IMG_NUM_W-1 -> 0), rd_bank=rd_ptr, rd_busy=1, bank READING, R_ACTIVE.
  - R_ACTIVE & rd_done -> bank FREE, rd_ptr toggles, rd_busy=0, R_IDLE.
  - image_number never changes while R_ACTIVE.
- Simultaneous events:
  - wr_done and rd_done in the same cycle touch different banks; both apply.
  - wr_done making a bank FULL: reader launch occurs no earlier than 1 cycle later.
  - rd_done freeing the bank wr_ptr waits on: grant occurs no earlier than 1 cycle later.
- Stall: with both banks non-FREE and writer idle, wr_grant stays 0 while wr_req is held; there is no timeout.
- proto_err is set by any of:
  - wr_done while W_IDLE.
  - rd_done while R_IDLE.
  - wr_done and wr_grant in the same cycle.
- Illegal pulses cause no state change.

Optional Feature:
- Macro BIT_SCHED_DROP_EN.
- With the macro: in W_IDLE & wr_req, if bank[wr_ptr]!=FREE, bank[~wr_ptr]==FULL and R_ACTIVE:
  - grant bank ~wr_ptr (it goes FULL->WRITING) and increment drop_count, saturating at all-ones.
  - rd_ptr is unchanged, so the reader later consumes the fresher frame.
  - If the reader would launch on that bank in the same cycle, the launch wins and no drop occurs.
- Without the macro: no recycling; the writer stalls; drop_count is constant 0.

Decomposition:
- Package bit_sched_pkg holds:
  - bank_state_t enum {BANK_FREE, BANK_WRITING, BANK_FULL, BANK_READING}.
  - wr_state_t {W_IDLE, W_ACTIVE} and rd_state_t {R_IDLE, R_ACTIVE}.
  - localparam NUM_BANKS=2.
- No sub-module: the two small FSMs and the bank-state array live in one module.

Test Plan:
- Reset, then wr_req=1: wr_grant pulse next cycle with wr_bank=0. Then wr_done: banks_full=01, image_number=1, rd_bank=0, rd_busy=1 within 2 cycles.
- Continuous frames: writer and reader alternate banks 0,1,0,1; image_number counts 1..15,0,1 across 17 frames; proto_err stays 0.
- Back-pressure: bank0 READING, bank1 FULL, wr_req held -> no wr_grant until rd_done. Grant to bank0 exactly 2 cycles after rd_done (free at +1, grant at +2).
- Same-cycle wr_done (bank1) and rd_done (bank0): bank0 FREE, bank1 FULL; reader launches on bank1 the next cycle.
- Protocol error: rd_done in R_IDLE -> proto_err=1 and stays 1; a later pclk_reset_n=0 mid-write clears everything and the next wr_req is granted bank 0.
- With BIT_SCHED_DROP_EN: bank0 READING, bank1 FULL, wr_req -> grant wr_bank=1, drop_count=1. After wr_done and rd_done, reader launches on bank 1.
